// File: rtl/aes_input_loader.sv
// rtl/aes_input_loader.sv - assembles key/plaintext words and launches AES_top with a timeout
//
// Ports:
//   AES_clk, AES_rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready/in_word  32-bit host word handshake
//   in_is_key                  1 = key word, 0 = plaintext word
//   AES_en                     core enable, high for the whole RUN state
//   AES_key_in, AES_data_in    assembled 128-bit key and block (registered)
//   AES_data_out_valid         completion flag from the core (sampled in RUN only)
//   busy                       high in RUN and GAP
//   timeout                    one-cycle pulse on the RUN cycle that is aborted
module aes_input_loader #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic         in_is_key,
  output logic         AES_en,
  output logic [127:0] AES_key_in,
  output logic [127:0] AES_data_in,
  input  logic         AES_data_out_valid,
  output logic         busy,
  output logic         timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_GAP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      key_cnt;
  logic [1:0]      data_cnt;
  logic            key_valid;
  logic            data_full;
  logic [CW-1:0]   run_cnt;
  logic [127:0]    key_reg;
  logic [127:0]    data_reg;

  logic            key_acc;
  logic            data_acc;
  logic            key_valid_nxt;
  logic            data_full_nxt;
  logic            run_tmo;

  assign key_acc  = in_valid & in_ready & in_is_key;
  assign data_acc = in_valid & in_ready & ~in_is_key;

  // Look-ahead flag values so launch happens on the same edge that
  // accepts the completing word, whether it is key or data.
  always_comb begin
    key_valid_nxt = key_valid;
    if (key_acc && key_cnt == 2'd3)
      key_valid_nxt = 1'b1;
    else if (key_acc && key_cnt == 2'd0)
      key_valid_nxt = 1'b0;
  end

  assign data_full_nxt = data_full | (data_acc & (data_cnt == 2'd3));
  assign run_tmo       = (run_cnt == TMO);

  // State register
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n)
      state <= S_LOAD;
    else
      state <= state_nxt;
  end

  // Next-state logic; valid beats timeout when both land on the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (data_full_nxt && key_valid_nxt) state_nxt = S_RUN;
      S_RUN:  if (AES_data_out_valid || run_tmo)  state_nxt = S_GAP;
      S_GAP:  state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    AES_en   = 1'b0;
    busy     = 1'b0;
    timeout  = 1'b0;
    in_ready = 1'b0;
    case (state)
      S_LOAD: in_ready = AES_rst_n & ~(data_full & ~in_is_key);
      S_RUN: begin
        AES_en  = 1'b1;
        busy    = 1'b1;
        timeout = run_tmo & ~AES_data_out_valid;
      end
      S_GAP:  busy = 1'b1;
      default: ;
    endcase
  end

  // Word assembly, flags and RUN cycle counter
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      key_reg   <= '0;
      data_reg  <= '0;
      key_cnt   <= 2'd0;
      data_cnt  <= 2'd0;
      key_valid <= 1'b0;
      data_full <= 1'b0;
      run_cnt   <= '0;
    end else begin
      if (key_acc) begin
        case (key_cnt)
          2'd0: key_reg[127:96] <= in_word;
          2'd1: key_reg[95:64]  <= in_word;
          2'd2: key_reg[63:32]  <= in_word;
          default: key_reg[31:0] <= in_word;
        endcase
        key_cnt <= key_cnt + 2'd1;
      end
      key_valid <= key_valid_nxt;

      if (data_acc) begin
        case (data_cnt)
          2'd0: data_reg[127:96] <= in_word;
          2'd1: data_reg[95:64]  <= in_word;
          2'd2: data_reg[63:32]  <= in_word;
          default: data_reg[31:0] <= in_word;
        endcase
        data_cnt <= data_cnt + 2'd1;
      end
      data_full <= data_full_nxt;

      case (state)
        S_LOAD: if (state_nxt == S_RUN) run_cnt <= CW'(1);
        S_RUN:  if (!run_tmo) run_cnt <= run_cnt + CW'(1);
        S_GAP: begin
          // Key and key_valid survive; only the data side is re-armed.
          data_full <= 1'b0;
          data_cnt  <= 2'd0;
          run_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign AES_key_in  = key_reg;
  assign AES_data_in = data_reg;

endmodule

// File: tb/tb_aes_input_loader.sv
// tb/tb_aes_input_loader.sv - directed self-checking bench for aes_input_loader
module tb_aes_input_loader;

  logic         AES_clk = 1'b0;
  logic         AES_rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_word = '0;
  logic         in_is_key = 1'b0;
  logic         AES_en;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_in;
  logic         AES_data_out_valid = 1'b0;
  logic         busy;
  logic         timeout;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] KEY_A  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] DATA_A = 128'h000000a5_00000000_00000000_00000000;
  localparam logic [127:0] DATA_B = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;
  localparam logic [127:0] DATA_C = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY_D  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] DATA_D = 128'h3243f6a8_885a308d_313198a2_e0370734;

  aes_input_loader #(.TIMEOUT_CYCLES(64)) dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_word            (in_word),
    .in_is_key          (in_is_key),
    .AES_en             (AES_en),
    .AES_key_in         (AES_key_in),
    .AES_data_in        (AES_data_in),
    .AES_data_out_valid (AES_data_out_valid),
    .busy               (busy),
    .timeout            (timeout)
  );

  always #5 AES_clk = ~AES_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AES_clk);
    #1;
  endtask

  task automatic send(input logic k, input logic [31:0] w);
    in_valid  = 1'b1;
    in_is_key = k;
    in_word   = w;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic send128(input logic k, input logic [127:0] v);
    send(k, v[127:96]);
    send(k, v[95:64]);
    send(k, v[63:32]);
    send(k, v[31:0]);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_en", AES_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_key", AES_key_in, 0);
    chk("rst_data", AES_data_in, 0);
    tick();
    tick();
    AES_rst_n = 1'b1;
    #1;
    chk("load_ready", in_ready, 1);

    // Basic launch
    send128(1'b1, KEY_A);
    chk("key_only_no_en", AES_en, 0);
    send(1'b0, DATA_A[127:96]);
    send(1'b0, DATA_A[95:64]);
    send(1'b0, DATA_A[63:32]);
    chk("pre_launch_en", AES_en, 0);
    send(1'b0, DATA_A[31:0]);
    chk("launch_en", AES_en, 1);
    chk("launch_busy", busy, 1);
    chk("launch_ready", in_ready, 0);
    chk("launch_key", AES_key_in, KEY_A);
    chk("launch_data", AES_data_in, DATA_A);

    // Completion on RUN cycle 10
    for (int k = 1; k < 10; k++) begin
      chk("run_en_hold", AES_en, 1);
      tick();
    end
    AES_data_out_valid = 1'b1;
    #1;
    chk("done_no_timeout", timeout, 0);
    tick();
    AES_data_out_valid = 1'b0;
    chk("gap_en", AES_en, 0);
    chk("gap_busy", busy, 1);
    chk("gap_ready", in_ready, 0);
    tick();
    chk("rearm_ready", in_ready, 1);
    chk("rearm_busy", busy, 0);
    chk("rearm_key", AES_key_in, KEY_A);

    // Key reuse, then timeout with valid never asserted
    send128(1'b0, DATA_B);
    chk("reuse_en", AES_en, 1);
    chk("reuse_key", AES_key_in, KEY_A);
    chk("reuse_data", AES_data_in, DATA_B);
    for (int k = 1; k <= 64; k++) begin
      chk("tmo_en", AES_en, 1);
      chk("tmo_pulse", timeout, (k == 64) ? 128'd1 : 128'd0);
      tick();
    end
    chk("tmo_gap_en", AES_en, 0);
    chk("tmo_gap_pulse", timeout, 0);
    chk("tmo_gap_busy", busy, 1);
    tick();
    chk("tmo_load_ready", in_ready, 1);
    chk("tmo_load_busy", busy, 0);

    // Valid is ignored in LOAD
    AES_data_out_valid = 1'b1;
    tick();
    AES_data_out_valid = 1'b0;
    chk("load_valid_ignored", busy, 0);

    // Reset mid-RUN
    send128(1'b0, DATA_C);
    chk("c_en", AES_en, 1);
    tick();
    tick();
    AES_rst_n = 1'b0;
    #1;
    chk("arst_en", AES_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_key", AES_key_in, 0);
    chk("arst_data", AES_data_in, 0);
    chk("arst_ready", in_ready, 0);
    tick();
    AES_rst_n = 1'b1;
    tick();
    chk("post_rst_idle", AES_en, 0);

    // Data-first after reset: key must be reloaded before launch
    send128(1'b0, DATA_D);
    chk("df_no_launch", AES_en, 0);
    in_valid  = 1'b1;
    in_is_key = 1'b0;
    in_word   = 32'hdeadbeef;
    #1;
    chk("df_stall_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    chk("df_stall_data", AES_data_in, DATA_D);
    in_is_key = 1'b1;
    #1;
    chk("df_key_ready", in_ready, 1);
    send(1'b1, KEY_D[127:96]);
    send(1'b1, KEY_D[95:64]);
    send(1'b1, KEY_D[63:32]);
    chk("df_pre_en", AES_en, 0);
    send(1'b1, KEY_D[31:0]);
    chk("df_launch_en", AES_en, 1);
    chk("df_key", AES_key_in, KEY_D);
    chk("df_data", AES_data_in, DATA_D);

    // Valid on RUN cycle 64 wins over timeout
    for (int k = 1; k < 64; k++) begin
      chk("race_no_pulse", timeout, 0);
      tick();
    end
    AES_data_out_valid = 1'b1;
    #1;
    chk("race_en", AES_en, 1);
    chk("race_pulse", timeout, 0);
    tick();
    AES_data_out_valid = 1'b0;
    chk("race_gap_en", AES_en, 0);
    chk("race_gap_pulse", timeout, 0);
    tick();
    chk("race_load_ready", in_ready, 1);
    chk("race_key_kept", AES_key_in, KEY_D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
